branch_redirect_ctl: RTL and testbench

//  Execute-stage redirect controller. Consumes the resolved branch/jump result (branch flag + 64-bit target)
//  and the PC the front end actually followed. On a mispredict it flushes the wrong-path front end, waits for
//  any outstanding ibus fetch to drain, then presents a redirect PC to fetch via a valid/ready handshake.

---
 rtl/branch_redirect_ctl_pkg.sv | 25 ++
 rtl/branch_redirect_ctl_stat_counter.sv | 32 +++
 rtl/branch_redirect_ctl.sv | 112 +++++++++++
 tb/tb_branch_redirect_ctl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctl_pkg.sv
// Shared types for the execute-stage redirect controller: FSM states, redirect
// request record and the default reset PC.
package branch_redirect_ctl_pkg;

  typedef logic        u1;
  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_DRAIN,
    RD_ISSUE
  } redirect_state_t;

  typedef struct packed {
    u1  valid;
    u64 pc;
  } redirect_req_t;

  localparam u64 RESET_PC_DEFAULT = 64'h8000_0000;

  function automatic u1 pc_aligned(input u64 pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/branch_redirect_ctl_stat_counter.sv
// 64-bit event counter used for redirect statistics; only present when
// BRANCH_REDIRECT_STATS_EN is defined, otherwise this file is empty.
`ifdef BRANCH_REDIRECT_STATS_EN
module branch_stat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/branch_redirect_ctl.sv
// Execute-stage redirect controller: flushes the wrong path, drains the ibus,
// then hands a redirect PC to fetch. Optional stats: BRANCH_REDIRECT_STATS_EN.
module branch_redirect_ctl
  import branch_redirect_ctl_pkg::*;
#(
  parameter u64 RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_branch,
  input  logic [63:0] ex_target,
  input  logic [63:0] pred_pc,
  input  logic        if_busy,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        flush_front,
  output logic        target_misalign,
`ifdef BRANCH_REDIRECT_STATS_EN
  output logic [63:0] stat_resolved,
  output logic [63:0] stat_mispred,
`endif
  output logic        busy
);

  redirect_state_t state_q, state_d;
  redirect_req_t   req_q, req_d;

  logic fire;
  logic is_idle;
  logic fire_idle;
  logic mispred;
  logic misalign;

  assign fire      = ex_valid & ~ex_stall & ex_branch;
  assign is_idle   = (state_q == RD_IDLE);
  // A resolved branch only counts while idle; younger work is already flushed otherwise.
  assign fire_idle = fire & is_idle;
  assign mispred   = fire_idle & (ex_target != pred_pc) & pc_aligned(ex_target);
  assign misalign  = fire_idle & ~pc_aligned(ex_target);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: begin
        if (mispred) begin
          state_d = if_busy ? RD_DRAIN : RD_ISSUE;
        end
      end
      RD_DRAIN: begin
        if (!if_busy) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (redirect_ready) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    req_d.valid = (state_d == RD_ISSUE);
    if (mispred) begin
      req_d.pc = ex_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RD_IDLE;
      req_q.valid <= 1'b0;
      req_q.pc    <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign redirect_valid  = req_q.valid;
  assign redirect_pc     = req_q.pc;
  assign flush_front     = mispred | ~is_idle;
  assign target_misalign = misalign;
  assign busy            = ~is_idle;

`ifdef BRANCH_REDIRECT_STATS_EN
  branch_stat_counter u_stat_resolved (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (fire_idle),
    .count_o (stat_resolved)
  );

  branch_stat_counter u_stat_mispred (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (mispred),
    .count_o (stat_mispred)
  );
`endif

  // A branch resolving while a redirect is pending means the pipe failed to flush.
  a_no_fire_when_busy : assert property (
    @(posedge clk) disable iff (!reset) !(fire && !is_idle)
  );

endmodule

// File: tb/tb_branch_redirect_ctl.sv
// Directed self-checking bench for branch_redirect_ctl; stats checks are built
// only when BRANCH_REDIRECT_STATS_EN is defined.
module tb_branch_redirect_ctl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_stall, ex_branch;
  logic [63:0] ex_target, pred_pc;
  logic        if_busy, redirect_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush_front, target_misalign, busy;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [63:0] stat_resolved, stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  branch_redirect_ctl dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_stall        (ex_stall),
    .ex_branch       (ex_branch),
    .ex_target       (ex_target),
    .pred_pc         (pred_pc),
    .if_busy         (if_busy),
    .redirect_ready  (redirect_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_front     (flush_front),
    .target_misalign (target_misalign),
`ifdef BRANCH_REDIRECT_STATS_EN
    .stat_resolved   (stat_resolved),
    .stat_mispred    (stat_mispred),
`endif
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    ex_valid = 1'b0; ex_stall = 1'b0; ex_branch = 1'b0;
    ex_target = '0; pred_pc = '0;
    if_busy = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic drive_fire(input logic [63:0] tgt, input logic [63:0] pred);
    ex_valid = 1'b1; ex_stall = 1'b0; ex_branch = 1'b1;
    ex_target = tgt; pred_pc = pred;
  endtask

  task automatic test_reset;
    drive_idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", redirect_pc, RST_PC); end
    checks++; if (flush_front !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_front); end
    checks++; if (target_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", target_misalign); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic test_correct_predict;
    drive_fire(64'h8000_0010, 64'h8000_0010);
    if_busy = 1'b0; redirect_ready = 1'b1;
    #1;
    checks++; if (flush_front !== 1'b0) begin errors++; $display("FAIL correct_flush: got %b want 0", flush_front); end
    checks++; if (target_misalign !== 1'b0) begin errors++; $display("FAIL correct_misalign: got %b want 0", target_misalign); end
    tick();
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL correct_valid c%0d: got %b want 0", k, redirect_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL correct_busy c%0d: got %b want 0", k, busy); end
      tick();
    end
  endtask

  task automatic test_mispred_fast;
    drive_fire(64'h8000_0100, 64'h8000_0008);
    if_busy = 1'b0; redirect_ready = 1'b1;
    #1;
    checks++; if (flush_front !== 1'b1) begin errors++; $display("FAIL fast_flush_T: got %b want 1", flush_front); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL fast_valid_T: got %b want 0", redirect_valid); end
    tick();
    ex_valid = 1'b0; ex_branch = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL fast_valid_T1: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 64'h8000_0100) begin errors++; $display("FAIL fast_pc_T1: got %h want 8000_0100", redirect_pc); end
    checks++; if (flush_front !== 1'b1) begin errors++; $display("FAIL fast_flush_T1: got %b want 1", flush_front); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fast_busy_T1: got %b want 1", busy); end
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL fast_valid_T2: got %b want 0", redirect_valid); end
    checks++; if (flush_front !== 1'b0) begin errors++; $display("FAIL fast_flush_T2: got %b want 0", flush_front); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fast_busy_T2: got %b want 0", busy); end
  endtask

  // Entered in the IDLE cycle right after a handshake.
  task automatic test_back_to_back;
    drive_fire(64'h8000_0500, 64'h8000_0100);
    redirect_ready = 1'b1;
    #1;
    checks++; if (flush_front !== 1'b1) begin errors++; $display("FAIL b2b_flush_T: got %b want 1", flush_front); end
    tick();
    drive_idle();
    redirect_ready = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_T1: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 64'h8000_0500) begin errors++; $display("FAIL b2b_pc_T1: got %h want 8000_0500", redirect_pc); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_T2: got %b want 0", busy); end
    drive_idle();
  endtask

  task automatic test_drain_and_stall;
    logic exp_valid, exp_flush;
    drive_fire(64'h8000_0200, 64'h8000_0204);
    if_busy = 1'b1; redirect_ready = 1'b0;
    #1;
    checks++; if (flush_front !== 1'b1) begin errors++; $display("FAIL drain_flush_T: got %b want 1", flush_front); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      if_busy = (k < 3);
      redirect_ready = (k >= 6);
      // Held branch (stalled) with a different target must not disturb the pending redirect.
      ex_valid = (k <= 5); ex_branch = (k <= 5); ex_stall = 1'b1;
      ex_target = 64'h9000_0000; pred_pc = 64'h9000_0040;
      #1;
      exp_valid = (k >= 4) && (k <= 6);
      exp_flush = (k <= 6);
      checks++; if (redirect_valid !== exp_valid) begin errors++; $display("FAIL drain_valid T%0d: got %b want %b", k, redirect_valid, exp_valid); end
      checks++; if (flush_front !== exp_flush) begin errors++; $display("FAIL drain_flush T%0d: got %b want %b", k, flush_front, exp_flush); end
      if (k <= 6) begin
        checks++; if (redirect_pc !== 64'h8000_0200) begin errors++; $display("FAIL drain_pc T%0d: got %h want 8000_0200", k, redirect_pc); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_end: got %b want 0", busy); end
    drive_idle();
    tick();
  endtask

  task automatic test_misalign;
    drive_fire(64'h8000_0102, 64'h8000_0010);
    if_busy = 1'b0; redirect_ready = 1'b1;
    #1;
    checks++; if (target_misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b want 1", target_misalign); end
    checks++; if (flush_front !== 1'b0) begin errors++; $display("FAIL misalign_flush: got %b want 0", flush_front); end
    tick();
    drive_idle();
    #1;
    checks++; if (target_misalign !== 1'b0) begin errors++; $display("FAIL misalign_after: got %b want 0", target_misalign); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL misalign_busy: got %b want 0", busy); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL misalign_valid: got %b want 0", redirect_valid); end
    tick();
  endtask

  task automatic test_reset_in_issue;
    drive_fire(64'h8000_0300, 64'h8000_0000);
    if_busy = 1'b0; redirect_ready = 1'b0;
    tick();
    drive_idle();
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_issue_pre: got %b want 1", redirect_valid); end
    #1 reset = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== RST_PC) begin errors++; $display("FAIL rst_issue_pc: got %h want %h", redirect_pc, RST_PC); end
    checks++; if (flush_front !== 1'b0) begin errors++; $display("FAIL rst_issue_flush: got %b want 0", flush_front); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_issue_busy: got %b want 0", busy); end
    tick();
    #2 reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", busy); end
    drive_fire(64'h8000_0400, 64'h8000_0404);
    redirect_ready = 1'b1;
    #1;
    checks++; if (flush_front !== 1'b1) begin errors++; $display("FAIL rst_refire_flush: got %b want 1", flush_front); end
    tick();
    drive_idle();
    redirect_ready = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_refire_valid: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 64'h8000_0400) begin errors++; $display("FAIL rst_refire_pc: got %h want 8000_0400", redirect_pc); end
    tick();
    drive_idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_refire_idle: got %b want 0", busy); end
  endtask

`ifdef BRANCH_REDIRECT_STATS_EN
  task automatic test_stats;
    reset = 1'b0;
    #3 reset = 1'b1;
    tick();
    checks++; if (stat_resolved !== 64'd0) begin errors++; $display("FAIL stats_clr_res: got %0d want 0", stat_resolved); end
    checks++; if (stat_mispred !== 64'd0) begin errors++; $display("FAIL stats_clr_mis: got %0d want 0", stat_mispred); end
    redirect_ready = 1'b1;
    drive_fire(64'h8000_0010, 64'h8000_0010); tick();
    drive_fire(64'h8000_0700, 64'h8000_0014); tick();
    ex_valid = 1'b0; tick();
    drive_fire(64'h8000_0710, 64'h8000_0710); tick();
    drive_fire(64'h8000_0800, 64'h8000_0714); ex_stall = 1'b1; tick();
    drive_fire(64'h8000_0900, 64'h8000_0720); tick();
    ex_valid = 1'b0; tick();
    drive_fire(64'h8000_0910, 64'h8000_0910); tick();
    drive_idle();
    tick();
    checks++; if (stat_resolved !== 64'd5) begin errors++; $display("FAIL stats_resolved: got %0d want 5", stat_resolved); end
    checks++; if (stat_mispred !== 64'd2) begin errors++; $display("FAIL stats_mispred: got %0d want 2", stat_mispred); end
  endtask
`endif

  initial begin
    test_reset();
    test_correct_predict();
    test_mispred_fast();
    test_back_to_back();
    test_drain_and_stall();
    test_misalign();
    test_reset_in_issue();
`ifdef BRANCH_REDIRECT_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
